// File: rtl/rq_responder.sv
// Pulse-width-qualified request receiver: measures an async RQ pulse, raises req_val, answers with a timed ACK.
// Optional RQ_RESPONDER_ERRCNT_EN adds a saturating err_cnt output.
module rq_responder #(
  parameter int MIN_W   = 28,
  parameter int MAX_W   = 36,
  parameter int ACK_LEN = 8,
  parameter int TIMEOUT = 200
) (
  input  logic       clk80MHz,
  input  logic       rst,
  input  logic       RQ,
  input  logic       resp_rdy,
  output logic       req_val,
  output logic       ACK,
  output logic       err,
  output logic [7:0] req_cnt
`ifdef RQ_RESPONDER_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, MEAS, HOLD, REQ, ACKS} state_t;

  localparam logic [5:0] MIN_W6   = 6'(MIN_W);
  localparam logic [5:0] MAX_W6   = 6'(MAX_W);
  localparam logic [7:0] ACK_L8   = 8'(ACK_LEN);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic       rq_m, rq_s, rq_p, rise;
  logic [2:0] vld_pipe;
  logic [5:0] wid, wid_nx;
  logic [7:0] tmo, tmo_nx, ack_cnt, ack_cnt_nx, req_cnt_nx;
  logic       req_val_nx, ack_nx, err_nx;

  // vld_pipe[2] marks that rq_p holds a real post-reset sample, so a level
  // already high at reset release never looks like a rise.
  assign rise = vld_pipe[2] & rq_s & ~rq_p;

  always_ff @(posedge clk80MHz) begin
    if (rst) begin
      state    <= IDLE;
      rq_m     <= 1'b0;
      rq_s     <= 1'b0;
      rq_p     <= 1'b0;
      vld_pipe <= '0;
      wid      <= '0;
      tmo      <= '0;
      ack_cnt  <= '0;
      req_cnt  <= '0;
      req_val  <= 1'b0;
      ACK      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      rq_m     <= RQ;
      rq_s     <= rq_m;
      rq_p     <= rq_s;
      vld_pipe <= {vld_pipe[1:0], 1'b1};
      wid      <= wid_nx;
      tmo      <= tmo_nx;
      ack_cnt  <= ack_cnt_nx;
      req_cnt  <= req_cnt_nx;
      req_val  <= req_val_nx;
      ACK      <= ack_nx;
      err      <= err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    wid_nx     = wid;
    tmo_nx     = tmo;
    ack_cnt_nx = ack_cnt;
    req_cnt_nx = req_cnt;
    req_val_nx = req_val;
    ack_nx     = ACK;
    err_nx     = 1'b0;
    case (state)
      IDLE: begin
        req_val_nx = 1'b0;
        ack_nx     = 1'b0;
        if (rise) begin
          state_nx = MEAS;
          wid_nx   = 6'd1;
        end
      end
      MEAS: begin
        if (rq_s) begin
          wid_nx = wid + 6'd1;
          if (wid == MAX_W6) state_nx = HOLD;
        end else if (wid >= MIN_W6) begin
          state_nx   = REQ;
          req_val_nx = 1'b1;
          tmo_nx     = '0;
        end else begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end
      end
      HOLD: begin
        if (!rq_s) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end
      end
      REQ: begin
        if (rise) err_nx = 1'b1;
        if (resp_rdy) begin
          state_nx   = ACKS;
          req_cnt_nx = req_cnt + 8'd1;
          req_val_nx = 1'b0;
          ack_nx     = 1'b1;
          ack_cnt_nx = 8'd1;
        end else if (tmo == TMO_LAST) begin
          state_nx   = IDLE;
          req_val_nx = 1'b0;
          err_nx     = 1'b1;
        end else begin
          tmo_nx = tmo + 8'd1;
        end
      end
      ACKS: begin
        if (rise) err_nx = 1'b1;
        if (ack_cnt == ACK_L8) begin
          state_nx = IDLE;
          ack_nx   = 1'b0;
        end else begin
          ack_cnt_nx = ack_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef RQ_RESPONDER_ERRCNT_EN
  always_ff @(posedge clk80MHz) begin
    if (rst) err_cnt <= '0;
    else if (err_nx && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
